// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared encodings for the control-unit memory strobe interface: responder
// FSM states, access opcode and default bus widths.
// -----------------------------------------------------------------------------
package mem_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/mem_word_array.sv
// -----------------------------------------------------------------------------
// mem_word_array
// DEPTH x DATA_W word storage with a synchronous write port and a registered
// read port. Contents are never reset; only the read register is.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (read register only)
//   we     in   write enable
//   re     in   read enable, loads the read register
//   addr   in   word address shared by both ports
//   wdata  in   write data
//   rdata  out  registered read data, held until the next read
// -----------------------------------------------------------------------------
module mem_word_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mem_access_responder.sv
// -----------------------------------------------------------------------------
// mem_access_responder
// Responder for single-cycle memoryRead / writeMemory strobes. Accepts one
// request in IDLE, waits WAIT_CYCLES states, performs the access against an
// internal word array and pulses done for one cycle.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   mem_read   in   read strobe (sampled in IDLE)
//   mem_write  in   write strobe (sampled in IDLE)
//   addr       in   word address, captured with the request
//   wdata      in   write data, captured with the request
//   rdata      out  read data, valid with done and held until the next read
//   done       out  one-cycle completion pulse
//   busy       out  high from the cycle after acceptance through done
//   req_err    out  one-cycle pulse for a rejected request
//   rd_count   out  completed reads, saturating  (MEM_ACCESS_COUNT_EN only)
//   wr_count   out  completed writes, saturating (MEM_ACCESS_COUNT_EN only)
//
// Optional feature macro: MEM_ACCESS_COUNT_EN (adds the access counters).
// -----------------------------------------------------------------------------
module mem_access_responder
    import mem_if_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy,
    output logic              req_err
`ifdef MEM_ACCESS_COUNT_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e            state_r;
    logic [3:0]        wait_cnt_r;
    logic              op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              done_r;
    logic              busy_r;
    logic              req_err_r;
    logic              strobe_s;
    logic              conflict_s;
    logic              we_s;
    logic              re_s;

    assign strobe_s   = mem_read | mem_write;
    assign conflict_s = mem_read & mem_write;

    // Array access happens on the edge that leaves RESP; reset abandons it.
    always_comb begin
        we_s = 1'b0;
        re_s = 1'b0;
        if (!reset && (state_r == ST_RESP)) begin
            we_s = (op_r == OP_WRITE);
            re_s = (op_r == OP_READ);
        end else begin
            we_s = 1'b0;
            re_s = 1'b0;
        end
    end

    // Request FSM, wait counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            op_r       <= OP_READ;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            req_err_r  <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            req_err_r <= 1'b0;
            // busy lags the FSM by one cycle so it covers the done cycle.
            busy_r    <= (state_r != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (conflict_s) begin
                        req_err_r <= 1'b1;
                    end else if (strobe_s) begin
                        op_r    <= mem_write ? OP_WRITE : OP_READ;
                        addr_r  <= addr;
                        wdata_r <= wdata;
                        if (WAIT_INIT == 4'd0) begin
                            state_r <= ST_RESP;
                        end else begin
                            state_r    <= ST_WAIT;
                            wait_cnt_r <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    req_err_r <= strobe_s;
                    if (wait_cnt_r == 4'd1) begin
                        state_r    <= ST_RESP;
                        wait_cnt_r <= 4'd0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    req_err_r <= strobe_s;
                    done_r    <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wait_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    mem_word_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (we_s),
        .re    (re_s),
        .addr  (addr_r),
        .wdata (wdata_r),
        .rdata (rdata)
    );

    assign done    = done_r;
    assign busy    = busy_r;
    assign req_err = req_err_r;

`ifdef MEM_ACCESS_COUNT_EN
    logic [15:0] rd_count_r;
    logic [15:0] wr_count_r;

    // Saturating counters of completed accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_r <= 16'd0;
            wr_count_r <= 16'd0;
        end else if (state_r == ST_RESP) begin
            if ((op_r == OP_READ) && (rd_count_r != 16'hFFFF)) begin
                rd_count_r <= rd_count_r + 16'd1;
            end
            if ((op_r == OP_WRITE) && (wr_count_r != 16'hFFFF)) begin
                wr_count_r <= wr_count_r + 16'd1;
            end
        end
    end

    assign rd_count = rd_count_r;
    assign wr_count = wr_count_r;
`endif

endmodule

// File: tb/tb_mem_access_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_access_responder
// Directed bench with a transaction-level reference model and a per-cycle
// compare process, plus literal pins on selected cycles.
// -----------------------------------------------------------------------------
module tb_mem_access_responder;

    localparam int W = 1;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       mem_read  = 1'b0;
    logic       mem_write = 1'b0;
    logic [3:0] addr      = 4'd0;
    logic [7:0] wdata     = 8'd0;
    logic [7:0] rdata;
    logic       done;
    logic       busy;
    logic       req_err;
`ifdef MEM_ACCESS_COUNT_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_responder #(
        .DATA_W      (8),
        .DEPTH       (16),
        .ADDR_W      (4),
        .WAIT_CYCLES (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .busy      (busy),
        .req_err   (req_err)
`ifdef MEM_ACCESS_COUNT_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    // Reference model: a pending transaction completes at a known edge number.
    logic [7:0] m_mem [16];
    bit         m_valid [16];
    bit         pend = 1'b0;
    int         pend_edge = 0;
    bit         p_wr;
    logic [3:0] p_addr;
    logic [7:0] p_data;
    int         k = 0;
    bit         started = 1'b0;
    logic [7:0] exp_rdata = 8'd0;
    bit         exp_rknown = 1'b0;
    bit         exp_done = 1'b0;
    bit         exp_busy = 1'b0;
    bit         exp_err = 1'b0;
    int         m_rd = 0;
    int         m_wr = 0;

    always @(posedge clk) begin : model
        bit engaged;
        k++;
        if (reset) begin
            pend = 1'b0; exp_rdata = 8'd0; exp_rknown = 1'b1;
            exp_done = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
            m_rd = 0; m_wr = 0; started = 1'b1;
        end else begin
            engaged  = pend;
            exp_busy = pend;
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (pend && k == pend_edge) begin
                exp_done = 1'b1;
                pend = 1'b0;
                if (p_wr) begin
                    m_mem[p_addr] = p_data; m_valid[p_addr] = 1'b1;
                    if (m_wr < 65535) m_wr++;
                end else begin
                    exp_rdata = m_mem[p_addr]; exp_rknown = m_valid[p_addr];
                    if (m_rd < 65535) m_rd++;
                end
            end
            if (mem_read || mem_write) begin
                if (engaged || (mem_read && mem_write)) begin
                    exp_err = 1'b1;
                end else begin
                    pend = 1'b1; pend_edge = k + 1 + W;
                    p_wr = mem_write; p_addr = addr; p_data = wdata;
                end
            end
        end
    end

    typedef struct {
        int         sel;
        logic [7:0] val;
        int         id;
    } pin_t;
    pin_t pin_q[$];
    int   pin_id = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare process: model every cycle, then any literal pins.
    always @(negedge clk) begin : cmp
        pin_t p;
        if (started) begin
            if (exp_rknown) chk("rdata", {8'd0, rdata}, {8'd0, exp_rdata});
            chk("done",    {15'd0, done},    {15'd0, exp_done});
            chk("busy",    {15'd0, busy},    {15'd0, exp_busy});
            chk("req_err", {15'd0, req_err}, {15'd0, exp_err});
`ifdef MEM_ACCESS_COUNT_EN
            chk("rd_count", rd_count, 16'(m_rd));
            chk("wr_count", wr_count, 16'(m_wr));
`endif
        end
        while (pin_q.size() > 0) begin
            p = pin_q.pop_front();
            case (p.sel)
                0: begin
                    chk($sformatf("pin%0d_rdata", p.id), {8'd0, rdata}, {8'd0, p.val});
                    chk($sformatf("pin%0d_rdata_model", p.id), {8'd0, exp_rdata}, {8'd0, p.val});
                end
                1: begin
                    chk($sformatf("pin%0d_done", p.id), {15'd0, done}, {15'd0, p.val[0]});
                    chk($sformatf("pin%0d_done_model", p.id), {15'd0, exp_done}, {15'd0, p.val[0]});
                end
                2: begin
                    chk($sformatf("pin%0d_busy", p.id), {15'd0, busy}, {15'd0, p.val[0]});
                    chk($sformatf("pin%0d_busy_model", p.id), {15'd0, exp_busy}, {15'd0, p.val[0]});
                end
                default: begin
                    chk($sformatf("pin%0d_req_err", p.id), {15'd0, req_err}, {15'd0, p.val[0]});
                    chk($sformatf("pin%0d_req_err_model", p.id), {15'd0, exp_err}, {15'd0, p.val[0]});
                end
            endcase
        end
    end

    // One clock of stimulus: inputs set on the falling edge, sampled on the next rising edge.
    task automatic cyc(input bit r, input bit w, input bit rs, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        mem_read = r; mem_write = w; reset = rs; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    // Literal expectation for the outputs seen after the most recent edge.
    task automatic pin(input int sel, input logic [7:0] v);
        pin_t p;
        p.sel = sel; p.val = v; p.id = pin_id;
        pin_q.push_back(p);
        pin_id++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 8'd0);
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 8'd0);
        pin(0, 8'h00); pin(1, 8'd0); pin(2, 8'd0); pin(3, 8'd0);

        // Write A5 to 3: done two edges after the strobe edge, busy for two cycles
        cyc(1'b0, 1'b1, 1'b0, 4'd3, 8'hA5); pin(2, 8'd0); pin(1, 8'd0);
        idle(1); pin(2, 8'd1); pin(1, 8'd0);
        idle(1); pin(1, 8'd1); pin(2, 8'd1); pin(3, 8'd0);
        idle(1); pin(1, 8'd0); pin(2, 8'd0);

        // Read 3 back, then rdata holds
        cyc(1'b1, 1'b0, 1'b0, 4'd3, 8'd0); idle(2); pin(1, 8'd1); pin(0, 8'hA5);
        idle(2); pin(0, 8'hA5); pin(1, 8'd0);

        // Back-to-back write 3C to 15 then read 15
        cyc(1'b0, 1'b1, 1'b0, 4'd15, 8'h3C); idle(2);
        cyc(1'b1, 1'b0, 1'b0, 4'd15, 8'd0); idle(1); pin(0, 8'hA5);
        idle(1); pin(1, 8'd1); pin(0, 8'h3C);

        // Both strobes in IDLE: rejected, no access
        cyc(1'b1, 1'b1, 1'b0, 4'd3, 8'h00); pin(3, 8'd1); pin(2, 8'd0); pin(1, 8'd0);
        idle(1); pin(3, 8'd0); pin(1, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'd3, 8'd0); idle(2); pin(0, 8'hA5); pin(1, 8'd1);

        // Strobe during WAIT: rejected, write still completes
        cyc(1'b0, 1'b1, 1'b0, 4'd5, 8'h77); cyc(1'b1, 1'b0, 1'b0, 4'd9, 8'd0); pin(3, 8'd1);
        idle(1); pin(1, 8'd1); pin(3, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'd5, 8'd0); idle(2); pin(0, 8'h77);

        // Strobe during RESP: rejected, first write lands
        cyc(1'b0, 1'b1, 1'b0, 4'd6, 8'h66); idle(1);
        cyc(1'b0, 1'b1, 1'b0, 4'd6, 8'h99); pin(3, 8'd1); pin(1, 8'd1);
        idle(1); cyc(1'b1, 1'b0, 1'b0, 4'd6, 8'd0); idle(2); pin(0, 8'h66);

        // Reset during WAIT of a write of FF to 3
        cyc(1'b0, 1'b1, 1'b0, 4'd3, 8'hFF); cyc(1'b0, 1'b0, 1'b1, 4'd0, 8'd0);
        pin(2, 8'd0); pin(1, 8'd0); pin(0, 8'h00);
        idle(2); pin(1, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'd3, 8'd0); idle(2); pin(0, 8'hA5);

        // Reset on the completing edge of a write of 11 to 3
        cyc(1'b0, 1'b1, 1'b0, 4'd3, 8'h11); idle(1); cyc(1'b0, 1'b0, 1'b1, 4'd0, 8'd0); pin(1, 8'd0);
        idle(1); cyc(1'b1, 1'b0, 1'b0, 4'd3, 8'd0); idle(2); pin(0, 8'hA5);

        // Read strobe held four cycles: accept, reject, reject, accept
        cyc(1'b1, 1'b0, 1'b0, 4'd15, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'd15, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'd15, 8'd0); pin(1, 8'd1); pin(3, 8'd1); pin(0, 8'h3C);
        cyc(1'b1, 1'b0, 1'b0, 4'd15, 8'd0); pin(3, 8'd0); pin(1, 8'd0); pin(2, 8'd0);
        idle(2); pin(1, 8'd1); pin(0, 8'h3C);

        // Pattern sweep over the upper addresses
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 4'(8 + i), 8'(8'h21 * (i + 1))); idle(2);
        end
        for (int i = 5; i >= 0; i--) begin
            cyc(1'b1, 1'b0, 1'b0, 4'(8 + i), 8'd0); idle(2);
        end
        pin(0, 8'h21);

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
